// File: rtl/in_fm_pkg.sv
// Shared tile geometry helpers and FSM encoding for the in_fm FIFO-to-buffer stage.
package in_fm_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_BUF = 2'd1;
    localparam logic [1:0] LOAD     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    function automatic int unsigned calc_tr_in(input int unsigned tr, input int unsigned k,
                                               input int unsigned s);
        return (tr - 1) * s + k;
    endfunction

    function automatic int unsigned calc_tc_in(input int unsigned tc, input int unsigned k,
                                               input int unsigned s);
        return (tc - 1) * s + k;
    endfunction

    function automatic int unsigned calc_tile_words(input int unsigned tr_in,
                                                    input int unsigned tc_in);
        return tr_in * tc_in;
    endfunction

endpackage

// File: rtl/in_fm_fifo_to_buf_if.sv
// Tile control, load-FIFO and input-buffer signals of the in_fm FIFO-to-buffer stage.
interface in_fm_fifo_to_buf_if #(
    parameter int DW = 32,
    parameter int AW = 12,
    parameter int Tn = 16
) ();
    logic          tile_start;
    logic          tile_done;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [Tn-1:0] buf_wr_ena;
    logic          buf_wr_sel;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic          buf_rd_sel;
    logic          buf_ready;
    logic          buf_release;

    modport master (
        input  tile_start, fifo_data, fifo_empty, buf_release,
        output tile_done, fifo_pop, buf_wr_ena, buf_wr_sel, buf_wr_addr, buf_wr_data,
               buf_rd_sel, buf_ready
    );

    modport slave (
        output tile_start, fifo_data, fifo_empty, buf_release,
        input  tile_done, fifo_pop, buf_wr_ena, buf_wr_sel, buf_wr_addr, buf_wr_data,
               buf_rd_sel, buf_ready
    );
endinterface

// File: rtl/in_fm_pingpong_ctrl.sv
// Ping-pong buffer-set bookkeeping: per-set full flags, write set and read set.
module in_fm_pingpong_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic rel,
    output logic wr_sel,
    output logic rd_sel,
    output logic wr_full,
    output logic rd_full
);
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       rel_ok;

    assign rel_ok  = rel && full[rd_sel];
    assign wr_full = full[wr_sel];
    assign rd_full = full[rd_sel];

    // Release and completion never target the same set, so applying both is safe.
    always_comb begin
        full_nxt = full;
        if (rel_ok)
            full_nxt[rd_sel] = 1'b0;
        if (done)
            full_nxt[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full <= full_nxt;
            if (done)
                wr_sel <= ~wr_sel;
            if (rel_ok)
                rd_sel <= ~rd_sel;
        end
    end
endmodule

// File: rtl/in_fm_fifo_to_buf.sv
// Pops load-FIFO words and scatters them channel-major into Tn per-channel buffer banks,
// alternating between two buffer sets so loading overlaps with compute.
module in_fm_fifo_to_buf
    import in_fm_pkg::*;
#(
    parameter int AW = 12,
    parameter int CW = 16,
    parameter int DW = 32,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int Tn = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic              clk,
    input  logic              rst,
    in_fm_fifo_to_buf_if.master bus
);
    localparam int unsigned TR_IN      = calc_tr_in(Tr, K, S);
    localparam int unsigned TC_IN      = calc_tc_in(Tc, K, S);
    localparam int unsigned TILE_WORDS = calc_tile_words(TR_IN, TC_IN);
    localparam int          CHW        = (Tn > 1) ? $clog2(Tn) : 1;

    localparam logic [CW-1:0]  POP_TOTAL = CW'(Tn * TILE_WORDS);
    localparam logic [CW-1:0]  COL_LAST  = CW'(TC_IN - 1);
    localparam logic [CW-1:0]  ROW_LAST  = CW'(TR_IN - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(Tn - 1);

    logic [1:0]     state;
    logic [CW-1:0]  pop_cnt;
    logic [CW-1:0]  row_cnt;
    logic [CW-1:0]  col_cnt;
    logic [CHW-1:0] ch_cnt;
    logic [AW-1:0]  addr_cnt;
    logic           pop;
    logic           pop_d1;
    logic           col_wrap;
    logic           row_wrap;
    logic           ch_wrap;
    logic           last_wr;
    logic           load_entry;
    logic           wr_sel;
    logic           rd_sel;
    logic           wr_full;
    logic           rd_full;

    assign pop        = (state == LOAD) && !bus.fifo_empty && (pop_cnt < POP_TOTAL);
    assign col_wrap   = (col_cnt == COL_LAST);
    assign row_wrap   = (row_cnt == ROW_LAST);
    assign ch_wrap    = (ch_cnt == CH_LAST);
    assign last_wr    = pop_d1 && col_wrap && row_wrap && ch_wrap;
    assign load_entry = (state == WAIT_BUF) && !wr_full;

    assign bus.fifo_pop   = pop;
    assign bus.tile_done  = (state == DONE);
    assign bus.buf_wr_sel = wr_sel;
    assign bus.buf_rd_sel = rd_sel;
    assign bus.buf_ready  = rd_full;

    in_fm_pingpong_ctrl u_pingpong (
        .clk     (clk),
        .rst     (rst),
        .done    (state == DONE),
        .rel     (bus.buf_release),
        .wr_sel  (wr_sel),
        .rd_sel  (rd_sel),
        .wr_full (wr_full),
        .rd_full (rd_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (bus.tile_start) state <= WAIT_BUF;
                WAIT_BUF: if (!wr_full)       state <= LOAD;
                LOAD:     if (last_wr)        state <= DONE;
                default:                      state <= IDLE;
            endcase
        end
    end

    // FIFO data lands one cycle after the pop, so counters advance on pop_d1, not pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            ch_cnt   <= '0;
            addr_cnt <= '0;
            pop_d1   <= 1'b0;
        end else if (load_entry) begin
            pop_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            ch_cnt   <= '0;
            addr_cnt <= '0;
            pop_d1   <= 1'b0;
        end else begin
            pop_d1 <= pop;
            if (pop)
                pop_cnt <= pop_cnt + 1'b1;
            if (pop_d1) begin
                if (col_wrap) begin
                    col_cnt <= '0;
                    if (row_wrap) begin
                        row_cnt  <= '0;
                        ch_cnt   <= ch_wrap ? '0 : ch_cnt + 1'b1;
                        addr_cnt <= '0;
                    end else begin
                        row_cnt  <= row_cnt + 1'b1;
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end else begin
                    col_cnt  <= col_cnt + 1'b1;
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.buf_wr_ena  <= '0;
            bus.buf_wr_addr <= '0;
            bus.buf_wr_data <= '0;
        end else begin
            bus.buf_wr_ena <= pop_d1 ? (Tn'(1) << ch_cnt) : '0;
            if (pop_d1) begin
                bus.buf_wr_addr <= addr_cnt;
                bus.buf_wr_data <= bus.fifo_data;
            end
        end
    end
endmodule

// File: tb/tb_in_fm_fifo_to_buf.sv
// Bench for in_fm_fifo_to_buf: a default-geometry instance and a small-geometry instance
// (Tr=4, Tc=2, K=3, S=2) checked every cycle against a tile-level write/ping-pong model.
module tb_in_fm_fifo_to_buf;
    localparam int unsigned TW[2]    = '{1188, 45};
    localparam int unsigned TOTAL[2] = '{19008, 720};

    logic clk = 1'b0;
    logic rst_b, rst_s;
    always #5 clk = ~clk;

    in_fm_fifo_to_buf_if #(.DW(32), .AW(12), .Tn(16)) bus_b ();
    in_fm_fifo_to_buf_if #(.DW(32), .AW(12), .Tn(16)) bus_s ();

    in_fm_fifo_to_buf dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
    in_fm_fifo_to_buf #(.Tr(4), .Tc(2), .K(3), .S(2)) dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Model state, one slot per instance.
    logic [1:0]  hist[2];
    int unsigned wc[2], gw[2], pcnt[2];
    logic [1:0]  full[2];
    logic        wsel[2], rsel[2];
    int unsigned tiles_done[2], pops_at_done[2], writes_at_done[2];
    int          last_pop_cyc[2], done_cyc[2];
    logic [15:0] last_ena[2], w44_ena, w45_ena, first_ena[2];
    logic [11:0] last_addr[2], w44_addr, w45_addr, first_addr[2];
    logic        first_sel[2];

    // FIFO models.
    bit          rnd_b = 1'b0;
    bit          pend_b = 1'b0, pend_s = 1'b0;
    int unsigned val_b = 0, val_s = 0;

    task automatic cmp(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s [dut%0d] cycle %0d: got %0h, want %0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic clear_model(input int d);
        hist[d] = '0; wc[d] = 0; gw[d] = 0; pcnt[d] = 0;
        full[d] = '0; wsel[d] = 1'b0; rsel[d] = 1'b0;
    endtask

    task automatic chk(input int d, input logic r, input logic pop, input logic [15:0] ena,
                       input logic sel, input logic [11:0] addr, input logic [31:0] data,
                       input logic done, input logic ready, input logic rdsel, input logic rel);
        logic        exp_wr, exp_done;
        logic [15:0] e_ena;
        if (r) begin
            cmp("outs_in_reset", d, 32'(|{pop, ena, sel, addr, data, done, ready, rdsel}), 0);
            clear_model(d);
            return;
        end
        exp_wr   = hist[d][1];
        exp_done = exp_wr && (wc[d] == TOTAL[d] - 1);
        cmp("wr_active", d, 32'(ena != 0), 32'(exp_wr));
        if (exp_wr) begin
            e_ena = 16'd1 << (wc[d] / TW[d]);
            cmp("wr_ena", d, 32'(ena), 32'(e_ena));
            cmp("wr_addr", d, 32'(addr), wc[d] % TW[d]);
            cmp("wr_data", d, data, gw[d]);
            cmp("wr_sel", d, 32'(sel), 32'(wsel[d]));
        end
        cmp("tile_done", d, 32'(done), 32'(exp_done));
        cmp("buf_ready", d, 32'(ready), 32'(full[d][rsel[d]]));
        cmp("buf_rd_sel", d, 32'(rdsel), 32'(rsel[d]));
        if (pop) begin
            cmp("pop_bound", d, 32'(pcnt[d] < TOTAL[d]), 1);
            pcnt[d]++;
            last_pop_cyc[d] = cyc;
        end
        hist[d] = {hist[d][0], pop};
        if (exp_wr) begin
            if (gw[d] == 0) begin first_ena[d] = ena; first_addr[d] = addr; first_sel[d] = sel; end
            if (d == 1 && wc[d] == 44) begin w44_ena = ena; w44_addr = addr; end
            if (d == 1 && wc[d] == 45) begin w45_ena = ena; w45_addr = addr; end
            last_ena[d] = ena; last_addr[d] = addr;
            wc[d]++; gw[d]++;
        end
        if (rel && full[d][rsel[d]]) begin
            full[d][rsel[d]] = 1'b0;
            rsel[d] = ~rsel[d];
        end
        if (exp_done) begin
            full[d][wsel[d]] = 1'b1;
            wsel[d] = ~wsel[d];
            tiles_done[d]++;
            done_cyc[d] = cyc;
            pops_at_done[d] = pcnt[d];
            writes_at_done[d] = wc[d];
            wc[d] = 0; pcnt[d] = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk(0, rst_b, bus_b.fifo_pop, bus_b.buf_wr_ena, bus_b.buf_wr_sel, bus_b.buf_wr_addr,
                bus_b.buf_wr_data, bus_b.tile_done, bus_b.buf_ready, bus_b.buf_rd_sel,
                bus_b.buf_release);
            chk(1, rst_s, bus_s.fifo_pop, bus_s.buf_wr_ena, bus_s.buf_wr_sel, bus_s.buf_wr_addr,
                bus_s.buf_wr_data, bus_s.tile_done, bus_s.buf_ready, bus_s.buf_rd_sel,
                bus_s.buf_release);
            cyc++;
        end
    end

    // Load FIFO: a popped word is presented the following cycle as an incrementing count.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_b) begin val_b = 0; pend_b = 1'b0; end
            if (rst_s) begin val_s = 0; pend_s = 1'b0; end
            if (pend_b) begin bus_b.fifo_data = val_b; val_b++; end
            if (pend_s) begin bus_s.fifo_data = val_s; val_s++; end
            bus_b.fifo_empty = rnd_b ? ($urandom_range(1) == 1) : 1'b0;
            bus_s.fifo_empty = 1'b0;
            #1;
            pend_b = bus_b.fifo_pop && !rst_b;
            pend_s = bus_s.fifo_pop && !rst_s;
        end
    end

    task automatic pulse_start(input int d);
        if (d == 0) bus_b.tile_start = 1'b1; else bus_s.tile_start = 1'b1;
        @(negedge clk);
        bus_b.tile_start = 1'b0;
        bus_s.tile_start = 1'b0;
    endtask

    task automatic pulse_release();
        bus_s.buf_release = 1'b1;
        @(negedge clk);
        bus_s.buf_release = 1'b0;
    endtask

    task automatic wait_tiles(input int d, input int unsigned n, input int budget,
                              input string name);
        for (int i = 0; i < budget; i++) begin
            if (tiles_done[d] >= n) break;
            @(negedge clk);
        end
        cmp(name, d, 32'(tiles_done[d] >= n), 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            clear_model(d);
            tiles_done[d] = 0; last_pop_cyc[d] = 0; done_cyc[d] = 0;
        end
        rst_b = 1'b1; rst_s = 1'b1;
        bus_b.tile_start = 1'b0; bus_b.fifo_data = '0; bus_b.fifo_empty = 1'b0;
        bus_b.buf_release = 1'b0;
        bus_s.tile_start = 1'b0; bus_s.fifo_data = '0; bus_s.fifo_empty = 1'b0;
        bus_s.buf_release = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        cmp("rst_ready", 0, 32'(bus_b.buf_ready), 0);
        cmp("rst_rd_sel", 0, 32'(bus_b.buf_rd_sel), 0);
        cmp("rst_wr_ena", 1, 32'(bus_s.buf_wr_ena), 0);
        cmp("rst_pop", 1, 32'(bus_s.fifo_pop), 0);
        @(negedge clk);
        rst_b = 1'b0; rst_s = 1'b0;
        @(negedge clk);

        // Full-size tile with the FIFO never empty.
        pulse_start(0);
        wait_tiles(0, 1, 20000, "t1_complete");
        #4;
        cmp("t1_pops", 0, pops_at_done[0], 19008);
        cmp("t1_writes", 0, writes_at_done[0], 19008);
        cmp("t1_last_addr", 0, 32'(last_addr[0]), 1187);
        cmp("t1_last_ena", 0, 32'(last_ena[0]), 32'h8000);
        cmp("t1_done_lat", 0, 32'(done_cyc[0] - last_pop_cyc[0]), 2);
        cmp("t1_ready", 0, 32'(bus_b.buf_ready), 1);
        cmp("t1_rd_sel", 0, 32'(bus_b.buf_rd_sel), 0);

        // Same tile with bubbles; data keeps counting from 19008.
        @(negedge clk);
        rnd_b = 1'b1;
        pulse_start(0);
        wait_tiles(0, 2, 60000, "t2_complete");
        #4;
        cmp("t2_writes", 0, writes_at_done[0], 19008);
        cmp("t2_ready", 0, 32'(bus_b.buf_ready), 1);
        rnd_b = 1'b0;

        // Small geometry: release while nothing is ready must be ignored.
        @(negedge clk);
        pulse_release();
        #4;
        cmp("idle_rel_rd_sel", 1, 32'(bus_s.buf_rd_sel), 0);
        cmp("idle_rel_ready", 1, 32'(bus_s.buf_ready), 0);

        @(negedge clk);
        pulse_start(1);
        wait_tiles(1, 1, 2000, "s1_complete");
        #4;
        cmp("s_w44_ena", 1, 32'(w44_ena), 32'h0001);
        cmp("s_w44_addr", 1, 32'(w44_addr), 44);
        cmp("s_w45_ena", 1, 32'(w45_ena), 32'h0002);
        cmp("s_w45_addr", 1, 32'(w45_addr), 0);
        cmp("s_last_ena", 1, 32'(last_ena[1]), 32'h8000);
        cmp("s_last_addr", 1, 32'(last_addr[1]), 44);
        @(negedge clk);
        pulse_start(1);
        wait_tiles(1, 2, 2000, "s2_complete");
        #4;
        cmp("both_full_ready", 1, 32'(bus_s.buf_ready), 1);
        @(negedge clk);
        pulse_start(1);
        for (int i = 0; i < 20; i++) begin
            #4;
            cmp("blocked_pop", 1, 32'(bus_s.fifo_pop), 0);
            @(negedge clk);
        end
        pulse_release();
        #4;
        cmp("rel_rd_sel", 1, 32'(bus_s.buf_rd_sel), 1);
        wait_tiles(1, 3, 2000, "s3_complete");

        // Reset in the middle of a tile.
        @(negedge clk);
        pulse_release();
        pulse_start(1);
        for (int i = 0; i < 2000; i++) begin
            if (wc[1] >= 500) break;
            @(negedge clk);
        end
        cmp("reach_500", 1, 32'(wc[1] >= 500), 1);
        @(negedge clk);
        rst_s = 1'b1;
        #4;
        cmp("mid_rst_ena", 1, 32'(bus_s.buf_wr_ena), 0);
        cmp("mid_rst_wr_sel", 1, 32'(bus_s.buf_wr_sel), 0);
        cmp("mid_rst_ready", 1, 32'(bus_s.buf_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        pulse_start(1);
        wait_tiles(1, 4, 2000, "post_rst_complete");
        #4;
        cmp("post_rst_first_ena", 1, 32'(first_ena[1]), 32'h0001);
        cmp("post_rst_first_addr", 1, 32'(first_addr[1]), 0);
        cmp("post_rst_first_sel", 1, 32'(first_sel[1]), 0);
        cmp("post_rst_rd_sel", 1, 32'(bus_s.buf_rd_sel), 0);
        cmp("post_rst_ready", 1, 32'(bus_s.buf_ready), 1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
